// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared channel state type, default constants and index-width helper
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP} ch_state_e;
    localparam int CLK_HZ_DEF       = 50_000_000;
    localparam int DEFAULT_HALF_DEF = CLK_HZ_DEF / 200;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one 50% duty divider channel with shadowed half-period, clean stop and sync
// Ports: clk_50MHz/reset (async, active-high); i_en run enable; i_sync phase restart;
//        i_wr/i_half config write; o_pend shadow pending; o_clk divided clock; o_tick rise strobe
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_half,
    output logic             o_pend,
    output logic             o_clk,
    output logic             o_tick
);
    ch_state_e        r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt, r_half, w_half, r_shadow, w_shadow, w_wr_half;
    logic             r_pend, w_pend, r_clk, w_clk, r_tick, w_tick, w_wrap, w_apply;

    assign w_wr_half = (i_half == '0) ? CNT_W'(1) : i_half;
    assign w_wrap    = (r_cnt == r_half - CNT_W'(1));

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_half   <= CNT_W'(DEFAULT_HALF);
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_half   <= w_half;
            r_shadow <= w_shadow;
            r_pend   <= w_pend;
            r_clk    <= w_clk;
            r_tick   <= w_tick;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_clk   = r_clk;
        w_tick  = 1'b0;
        w_apply = 1'b0;
        if (r_state == IDLE) begin
            w_cnt   = '0;
            w_clk   = 1'b0;
            w_apply = r_pend;
            w_state = i_en ? RUN : IDLE;
        end else if (i_sync) begin
            w_cnt   = '0;
            w_clk   = 1'b0;
            w_apply = r_pend;
            w_state = i_en ? RUN : IDLE;
        end else if (!i_en && !r_clk) begin
            // low phase: stopping now cannot produce a runt pulse
            w_cnt   = '0;
            w_state = IDLE;
        end else if (w_wrap) begin
            w_cnt  = '0;
            w_clk  = !r_clk;
            w_tick = !r_clk;
            if (r_clk) begin
                w_apply = r_pend;
                w_state = i_en ? RUN : IDLE;
            end
        end else begin
            w_cnt   = r_cnt + CNT_W'(1);
            w_state = i_en ? RUN : STOP;
        end
        // the apply uses the old shadow, so a write in a boundary cycle waits for the next one
        w_half   = w_apply ? r_shadow : r_half;
        w_shadow = i_wr ? w_wr_half : r_shadow;
        w_pend   = i_wr || (r_pend && !w_apply);
        if (i_wr && r_state == IDLE) begin
            w_half = w_wr_half;
            w_pend = 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_clk  = r_clk;
    assign o_tick = r_tick;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH runtime-programmable 50% duty clock dividers with tick strobes
// Ports: clk_50MHz/reset (async, active-high); en per-channel enable; sync phase restart;
//        cfg_valid/cfg_ready/cfg_ch/cfg_half config write; cfg_pend pending shadows;
//        clk_out divided clocks; tick rise strobes
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEF,
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = CLK_HZ / 200
) (
    input  logic                    clk_50MHz,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]        cfg_half,
    output logic [NUM_CH-1:0]       cfg_pend,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] w_wr;

    assign cfg_ready = 1'b1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // out-of-range cfg_ch values match no channel and are dropped
        assign w_wr[g] = cfg_valid && (cfg_ch == CH_W'(g));
        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_ch (
            .clk_50MHz(clk_50MHz),
            .reset    (reset),
            .i_en     (en[g]),
            .i_sync   (sync),
            .i_wr     (w_wr[g]),
            .i_half   (cfg_half),
            .o_pend   (cfg_pend[g]),
            .o_clk    (clk_out[g]),
            .o_tick   (tick[g])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench with a phase-arithmetic reference model of clk_div_multi
module tb_clk_div_multi;
    localparam int NCH = 4;
    localparam int CW  = 26;
    localparam int DH  = 5;

    logic           clk_50MHz = 1'b0;
    logic           reset     = 1'b1;
    logic           sync      = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [NCH-1:0] en        = '0;
    logic [NCH-1:0] cfg_pend, clk_out, tick;
    logic [1:0]     cfg_ch    = '0;
    logic [CW-1:0]  cfg_half  = '0;

    clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DH)) dut (
        .clk_50MHz(clk_50MHz),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_pend (cfg_pend),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] c, t, p;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, n_chk = 0, n_fail = 0;
    int   prev_rise[NCH], last_rise[NCH];

    // model: a running channel's period started at cycle m_t0; output is high for phase in [h, 2h)
    bit m_run[NCH], m_pend[NCH];
    int m_t0[NCH], m_h[NCH], m_sh[NCH];

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_pend[i] = 0; m_t0[i] = 0; m_h[i] = DH; m_sh[i] = 0;
        end
    endtask

    // consume this cycle's inputs and predict the outputs of the next cycle
    task automatic step();
        exp_t e;
        int   c, ph, nh;
        bit   wr, hi;
        c = cyc;
        e.cyc = c + 1;
        for (int i = 0; i < NCH; i++) begin
            wr = cfg_valid && (int'(cfg_ch) == i);
            nh = (cfg_half == 0) ? 1 : int'(cfg_half);
            if (!m_run[i]) begin
                if (wr) begin
                    m_h[i] = nh; m_pend[i] = 0; wr = 0;
                end else if (m_pend[i]) begin
                    m_h[i] = m_sh[i]; m_pend[i] = 0;
                end
                if (en[i]) begin
                    m_run[i] = 1; m_t0[i] = c + 1;
                end
            end else begin
                ph = c - m_t0[i];
                hi = ph >= m_h[i];
                if (sync || ph == 2 * m_h[i] - 1) begin
                    if (m_pend[i]) begin
                        m_h[i] = m_sh[i]; m_pend[i] = 0;
                    end
                    m_run[i] = en[i];
                    m_t0[i] = c + 1;
                end else if (!en[i] && !hi) begin
                    m_run[i] = 0;
                end
            end
            if (wr) begin
                m_sh[i] = nh; m_pend[i] = 1;
            end
            ph = c + 1 - m_t0[i];
            e.c[i] = m_run[i] && ph >= m_h[i];
            e.t[i] = m_run[i] && ph == m_h[i];
            e.p[i] = m_pend[i];
        end
        q.push_back(e);
    endtask

    task automatic go(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            @(posedge clk_50MHz);
            #1;
            sync = 1'b0;
            cfg_valid = 1'b0;
        end
    endtask

    task automatic wr_cfg(input int ch, input int h);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_half  = CW'(h);
    endtask

    task automatic wait_tick(input int ch);
        for (int k = 0; k < 40 && !tick[ch]; k++) go(1);
        chk("wait_tick", 32'(tick[ch]), 32'd1);
    endtask

    always @(negedge clk_50MHz) begin : mon
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("clk_out", 32'(clk_out), 32'(e.c));
            chk("tick", 32'(tick), 32'(e.t));
            chk("cfg_pend", 32'(cfg_pend), 32'(e.p));
        end
        for (int i = 0; i < NCH; i++)
            if (tick[i]) begin
                prev_rise[i] = last_rise[i];
                last_rise[i] = cyc;
            end
    end

    initial begin
        m_reset();
        repeat (2) @(posedge clk_50MHz);
        #1;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(cfg_pend), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;

        en = 4'b0001;
        go(40);
        chk("ch0_period_default", last_rise[0] - prev_rise[0], 10);

        for (int k = 0; k < 20 && !clk_out[0]; k++) go(1);
        chk("ch0_high_before_cfg", 32'(clk_out[0]), 32'd1);
        wr_cfg(0, 3);
        go(40);
        chk("ch0_period_half3", last_rise[0] - prev_rise[0], 6);

        wr_cfg(2, 0);
        go(2);
        en[2] = 1'b1;
        go(20);
        chk("ch2_period_clamped", last_rise[2] - prev_rise[2], 2);

        wr_cfg(0, 5);
        go(20);
        wait_tick(0);
        go(1);
        en[0] = 1'b0;
        go(20);
        chk("ch0_stopped", 32'(clk_out[0]), 32'd0);
        en[0] = 1'b1;
        go(12);
        wait_tick(0);
        go(1);
        en[0] = 1'b0;
        go(2);
        en[0] = 1'b1;
        go(30);
        chk("ch0_period_after_stop", last_rise[0] - prev_rise[0], 10);

        en[2] = 1'b0;
        wr_cfg(1, 7);
        go(1);
        en[1] = 1'b1;
        go(25);
        sync = 1'b1;
        go(1);
        chk("sync_low", 32'(clk_out[1:0]), 32'd0);
        go(30);
        for (int k = 0; k < 40 && !(m_run[0] && cyc - m_t0[0] == 2 * m_h[0] - 1); k++) go(1);
        chk("reach_boundary", 32'(m_run[0] && cyc - m_t0[0] == 2 * m_h[0] - 1), 32'd1);
        sync = 1'b1;
        go(20);

        for (int k = 0; k < 20 && !clk_out[0]; k++) go(1);
        wr_cfg(0, 9);
        go(1);
        chk("pend_before_reset", 32'(cfg_pend[0]), 32'd1);
        #3;
        reset = 1'b1;
        q.delete();
        #1;
        chk("async_rst_clk_out", 32'(clk_out), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_pend", 32'(cfg_pend), 32'd0);
        m_reset();
        repeat (2) @(posedge clk_50MHz);
        #1;
        reset = 1'b0;
        en = 4'b0001;
        go(30);
        chk("ch0_period_after_reset", last_rise[0] - prev_rise[0], 10);

        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
            sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) wr_cfg($urandom_range(0, 3), $urandom_range(0, 6));
            go(1);
        end
        go(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
